// File: rtl/prbs_ber_monitor_if.sv
// prbs_ber_monitor_if: demodulated symbol bus into the BER monitor
//   sym_I     signed DATA_W  demodulated I
//   sym_Q     signed DATA_W  demodulated Q
//   sym_valid 1              qualifies sym_I/sym_Q, one symbol per asserted cycle
//   master drives the bus (rx_top side), slave consumes it (prbs_ber_monitor)
interface prbs_ber_monitor_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sym_I;
    logic signed [DATA_W-1:0] sym_Q;
    logic                     sym_valid;
    modport master (output sym_I, sym_Q, sym_valid);
    modport slave  (input  sym_I, sym_Q, sym_valid);
endinterface

// File: rtl/prbs_ber_monitor.sv
// prbs_ber_monitor: 16-QAM slicer + self-synchronising PRBS-9 checker with saturating BER counters
//   clk_dsp       in   DSP clock
//   sys_rst_n     in   asynchronous active-low reset
//   sym_bus       in   symbol bus (slave modport of prbs_ber_monitor_if)
//   clear         in   synchronous counter clear, lock state untouched
//   locked        out  checker in LOCKED state
//   err_pulse     out  one-cycle pulse for an errored symbol while locked
//   bit_cnt       out  bits checked while locked, saturating
//   err_cnt       out  bit errors while locked, frozen together with bit_cnt
//   last_win_err  out  error count of the last completed window (only with BERMON_WIN_STATS_EN)
module prbs_ber_monitor #(
    parameter int                       DATA_W    = 16,
    parameter logic signed [DATA_W-1:0] SLICE_TH  = 16'sd512,
    parameter int                       LOCK_SYMS = 16,
    parameter int                       WIN_SYMS  = 256,
    parameter int                       LOSS_ERRS = 64,
    parameter int                       CNT_W     = 32,
    localparam int                      WERR_W    = $clog2(4 * WIN_SYMS) + 1
) (
    input  logic              clk_dsp,
    input  logic              sys_rst_n,
    prbs_ber_monitor_if.slave sym_bus,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [CNT_W-1:0]  err_cnt
`ifdef BERMON_WIN_STATS_EN
    ,
    output logic [WERR_W-1:0] last_win_err
`endif
);
    localparam int SYNC_W = $clog2(LOCK_SYMS + 1);
    localparam int WSYM_W = $clog2(WIN_SYMS);
    localparam logic signed [DATA_W-1:0] NEG_TH = -SLICE_TH;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [8:0]         r_q, r_d;
    logic [1:0]         fill_q, fill_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic [WSYM_W-1:0]  win_sym_q, win_sym_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   bit_q, bit_d, err_q, err_d;
    logic               pulse_q, pulse_d;
`ifdef BERMON_WIN_STATS_EN
    logic [WERR_W-1:0]  last_q, last_d;
`endif

    logic               sym_valid;
    logic [3:0]         nib, pred;
    logic [8:0]         r_walk;
    logic [2:0]         errs;
    logic [WERR_W-1:0]  win_err_sum;
    logic               sat;

    function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x);
        return (x >= SLICE_TH) ? 2'b11 : !x[DATA_W-1] ? 2'b10 : (x >= NEG_TH) ? 2'b00 : 2'b01;
    endfunction

    assign sym_valid   = sym_bus.sym_valid;
    assign nib         = {slice(sym_bus.sym_I), slice(sym_bus.sym_Q)};
    assign errs        = 3'($countones(nib ^ pred));
    assign win_err_sum = win_err_q + WERR_W'(errs);
    // bit_cnt + 4 overflows exactly when bit_cnt >= 2^CNT_W - 4
    assign sat         = &bit_q[CNT_W-1:2];

    // Four PRBS steps per symbol; SEARCH feeds back received bits, LOCKED free-runs on predictions
    always_comb begin
        r_walk = r_q;
        pred   = '0;
        for (int k = 3; k >= 0; k--) begin
            pred[k] = r_walk[8] ^ r_walk[4];
            r_walk  = {r_walk[7:0], (state_q == LOCKED) ? pred[k] : nib[k]};
        end
    end

    always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= SEARCH;
            r_q       <= '0;
            fill_q    <= '0;
            sync_q    <= '0;
            win_sym_q <= '0;
            win_err_q <= '0;
            bit_q     <= '0;
            err_q     <= '0;
            pulse_q   <= 1'b0;
`ifdef BERMON_WIN_STATS_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            sync_q    <= sync_d;
            win_sym_q <= win_sym_d;
            win_err_q <= win_err_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
            pulse_q   <= pulse_d;
`ifdef BERMON_WIN_STATS_EN
            last_q    <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        fill_d    = fill_q;
        sync_d    = sync_q;
        win_sym_d = win_sym_q;
        win_err_d = win_err_q;
        bit_d     = bit_q;
        err_d     = err_q;
        pulse_d   = 1'b0;
`ifdef BERMON_WIN_STATS_EN
        last_d    = last_q;
`endif
        if (sym_valid) begin
            r_d = r_walk;
            if (state_q == SEARCH) begin
                // first three symbols after entry only prime the shift register
                if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
                else sync_d = (errs == 3'd0) ? sync_q + SYNC_W'(1) : '0;
                if (sync_d == SYNC_W'(LOCK_SYMS)) begin
                    state_d   = LOCKED;
                    win_sym_d = '0;
                    win_err_d = '0;
                end
            end else begin
                pulse_d   = errs != 3'd0;
                win_sym_d = win_sym_q + WSYM_W'(1);
                win_err_d = win_err_sum;
                if (!sat) begin
                    bit_d = bit_q + CNT_W'(4);
                    err_d = err_q + CNT_W'(errs);
                end
                if (win_sym_q == WSYM_W'(WIN_SYMS - 1)) begin
                    win_sym_d = '0;
                    win_err_d = '0;
`ifdef BERMON_WIN_STATS_EN
                    last_d    = win_err_sum;
`endif
                    if (win_err_sum > WERR_W'(LOSS_ERRS)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        sync_d  = '0;
                    end
                end
            end
        end
        if (clear) begin
            bit_d = '0;
            err_d = '0;
        end
    end

    always_comb begin
        locked    = state_q == LOCKED;
        err_pulse = pulse_q;
        bit_cnt   = bit_q;
        err_cnt   = err_q;
`ifdef BERMON_WIN_STATS_EN
        last_win_err = last_q;
`endif
    end
endmodule

// File: tb/tb_prbs_ber_monitor.sv
// tb_prbs_ber_monitor: randomized bench for prbs_ber_monitor against a bit-history reference model
module tb_prbs_ber_monitor;
    localparam int     DATA_W    = 16;
    localparam int     CNT_W     = 12;
    localparam int     TH        = 512;
    localparam int     LOCK_SYMS = 16;
    localparam int     WIN_SYMS  = 256;
    localparam int     LOSS_ERRS = 64;
    localparam longint CNT_MAX   = (longint'(1) << CNT_W) - 1;

    logic             clk_dsp = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             locked, err_pulse;
    logic [CNT_W-1:0] bit_cnt, err_cnt;

    prbs_ber_monitor_if #(.DATA_W(DATA_W)) sym_bus ();

    prbs_ber_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_dsp   (clk_dsp),
        .sys_rst_n (sys_rst_n),
        .sym_bus   (sym_bus),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk_dsp = ~clk_dsp;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // reference model: last 9 bits kept as a plain bit history, counters as integers
    bit     hist[$];
    bit     m_locked, m_pulse;
    int     m_fill, m_sync, m_wsym, m_werr;
    longint m_bits, m_errs;

    task automatic model_reset();
        hist.delete();
        repeat (9) hist.push_back(1'b0);
        m_locked = 0; m_pulse = 0;
        m_fill = 0; m_sync = 0; m_wsym = 0; m_werr = 0;
        m_bits = 0; m_errs = 0;
    endtask

    function automatic logic [1:0] slice_ref(input int x);
        if (x >= TH) return 2'b11;
        if (x >= 0) return 2'b10;
        if (x >= -TH) return 2'b00;
        return 2'b01;
    endfunction

    task automatic model_step(input int ii, input int qq, input bit v, input bit c);
        logic [3:0] nib;
        bit p, rx;
        int errs;
        m_pulse = 0;
        if (v) begin
            nib = {slice_ref(ii), slice_ref(qq)};
            errs = 0;
            for (int k = 3; k >= 0; k--) begin
                p  = hist[0] ^ hist[4];
                rx = nib[k];
                if (p != rx) errs++;
                hist.push_back(m_locked ? p : rx);
                void'(hist.pop_front());
            end
            if (!m_locked) begin
                if (m_fill < 3) m_fill++;
                else m_sync = (errs == 0) ? m_sync + 1 : 0;
                if (m_sync == LOCK_SYMS) begin
                    m_locked = 1; m_wsym = 0; m_werr = 0;
                end
            end else begin
                m_pulse = errs != 0;
                if (m_bits + 4 <= CNT_MAX) begin
                    m_bits += 4; m_errs += errs;
                end
                m_wsym++;
                m_werr += errs;
                if (m_wsym == WIN_SYMS) begin
                    if (m_werr > LOSS_ERRS) begin
                        m_locked = 0; m_fill = 0; m_sync = 0;
                    end
                    m_wsym = 0; m_werr = 0;
                end
            end
        end
        if (c) begin
            m_bits = 0; m_errs = 0;
        end
    endtask

    // mode 0 nominal levels, 1 random inside the decision region, 2 decision boundaries
    function automatic int level(input logic [1:0] b, input int mode);
        bit pick;
        pick = $urandom_range(1);
        if (mode == 0) return (b == 2'b11) ? 768 : (b == 2'b10) ? 256 : (b == 2'b00) ? -256 : -768;
        if (mode == 1) return (b == 2'b11) ? int'($urandom_range(32767, TH)) :
                              (b == 2'b10) ? int'($urandom_range(TH - 1, 0)) :
                              (b == 2'b00) ? -int'($urandom_range(TH, 1)) :
                                             -int'($urandom_range(32768, TH + 1));
        return (b == 2'b11) ? (pick ? TH : 32767) :
               (b == 2'b10) ? (pick ? 0 : TH - 1) :
               (b == 2'b00) ? (pick ? -1 : -TH) :
                              (pick ? -TH - 1 : -32768);
    endfunction

    logic [8:0] tx = 9'h1FF;

    task automatic tx_nib(output logic [3:0] n);
        bit b;
        for (int k = 3; k >= 0; k--) begin
            b = tx[8] ^ tx[4];
            tx = {tx[7:0], b};
            n[k] = b;
        end
    endtask

    task automatic apply(input logic [3:0] nib, input bit v, input bit c, input int mode);
        int ii, qq;
        @(negedge clk_dsp);
        ii = level(nib[3:2], mode);
        qq = level(nib[1:0], mode);
        sym_bus.sym_I     = DATA_W'(ii);
        sym_bus.sym_Q     = DATA_W'(qq);
        sym_bus.sym_valid = v;
        clear             = c;
        @(posedge clk_dsp);
        model_step(ii, qq, v, c);
        #1;
        check("locked", locked, m_locked);
        check("err_pulse", err_pulse, m_pulse);
        check("bit_cnt", bit_cnt, m_bits);
        check("err_cnt", err_cnt, m_errs);
    endtask

    task automatic clean(input int n, input int mode);
        logic [3:0] nib;
        repeat (n) begin
            tx_nib(nib);
            apply(nib, 1, 0, mode);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] nib;
        int pulses;
        bit v, c;
        model_reset();
        sym_bus.sym_I = '0; sym_bus.sym_Q = '0; sym_bus.sym_valid = 1'b0;
        repeat (3) @(posedge clk_dsp);
        #1;
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_bits", bit_cnt, 0);
        check("rst_errs", err_cnt, 0);
        @(negedge clk_dsp);
        sys_rst_n = 1'b1;

        for (int s = 1; s <= 19; s++) begin
            clean(1, 0);
            if (s == 18) check("prelock18", locked, 0);
        end
        check("lock19", locked, 1);

        pulses = 0;
        for (int s = 0; s < 100; s++) begin
            clean(1, 0);
            pulses += int'(err_pulse);
        end
        check("bits100", bit_cnt, 400);
        check("errs100", err_cnt, 0);
        check("no_pulse", pulses, 0);

        tx_nib(nib);
        nib[1] = ~nib[1];
        apply(nib, 1, 0, 0);
        check("flip_pulse", err_pulse, 1);
        check("flip_err", err_cnt, 1);
        clean(1, 0);
        check("pulse_once", err_pulse, 0);
        clean(1, 0);
        check("no_reseed", err_cnt, 1);

        for (int s = 0; s < 600; s++) begin
            v = $urandom_range(3) != 0;
            c = $urandom_range(49) == 0;
            if (v) begin
                tx_nib(nib);
                if ($urandom_range(39) == 0) nib[$urandom_range(3)] ^= 1'b1;
            end else nib = 4'($urandom);
            apply(nib, v, c, int'($urandom_range(2)));
        end
        clean(4, 2);

        tx_nib(nib);
        nib[3] = ~nib[3];
        apply(nib, 1, 1, 1);
        check("clr_bits", bit_cnt, 0);
        check("clr_errs", err_cnt, 0);
        check("clr_pulse", err_pulse, 1);
        clean(1, 0);
        check("clr_bits4", bit_cnt, 4);

        for (int s = 0; s < 512; s++) apply(4'($urandom), 1, 0, 1);
        check("lost", locked, 0);
        clean(19, 1);
        check("relock", locked, 1);

        tx_nib(nib);
        apply(nib, 1, 1, 0);
        for (int s = 1; s <= 1030; s++) begin
            tx_nib(nib);
            if (s % 100 == 50) nib[0] = ~nib[0];
            apply(nib, 1, 0, 0);
        end
        check("sat_bits", bit_cnt, CNT_MAX - 3);
        check("sat_errs", err_cnt, 10);
        tx_nib(nib);
        nib[2] = ~nib[2];
        apply(nib, 1, 0, 0);
        check("sat_pulse", err_pulse, 1);
        check("sat_frozen", err_cnt, 10);
        apply(4'h0, 0, 1, 0);
        check("unfreeze_bits0", bit_cnt, 0);
        clean(1, 0);
        check("unfreeze_bits4", bit_cnt, 4);
        clean(5, 1);

        @(negedge clk_dsp);
        #2 sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_locked", locked, 0);
        check("arst_bits", bit_cnt, 0);
        check("arst_errs", err_cnt, 0);
        check("arst_pulse", err_pulse, 0);
        sym_bus.sym_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk_dsp);
        @(negedge clk_dsp);
        sys_rst_n = 1'b1;
        for (int s = 1; s <= 19; s++) begin
            clean(1, 0);
            if (s == 18) check("re_prelock18", locked, 0);
        end
        check("re_lock19", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
